match_turn_ctrl: RTL and testbench
==================================

# match_turn_ctrl

Turn sequencer for the 6x6 memory-match game. It accepts card picks from the cursor/button logic and reads each picked card's symbol from the card symbol RAM. It compares the two symbols of a turn, latches found pairs, and drives the reveal, found and score signals consumed by the LED grid driver and the display. A mismatched pair stays revealed for a programmable hold time before it is hidden again.

## Interface
- NUM_CARDS, 36, cards on the board; even, ≤ 2^ADDR_W
- ADDR_W, 6, card index width
- SYM_W, 5, symbol code width
- HIDE_CYCLES, 25_000_000, mismatch reveal time in clocks (0.5 s at 50 MHz); ≥ 2
- TURN_W, 8, turn counter width
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- new_game  in  1  synchronous restart, single-cycle pulse
- pick_valid  in  1  pick request
- pick_addr  in  ADDR_W  card picked
- pick_ready  out  1  controller can accept a pick
- sym_rd  out  1  symbol RAM read strobe
- sym_addr  out  ADDR_W  symbol RAM address
- sym_data  in  SYM_W  symbol RAM data; valid 1 cycle after sym_rd
- first_card, second_card  out  ADDR_W  cards revealed this turn
- show_first, show_second  out  1  reveal flags for those cards
- found  out  NUM_CARDS  bit i set = card i matched
- match_pulse, miss_pulse, reject_pulse  out  1  single-cycle events
- pairs_found  out  ADDR_W  matched pairs
- turns  out  TURN_W  completed turns, saturating
- game_over  out  1  all pairs found

## Operation
- States: PICK1, RD1, WAIT1, PICK2, RD2, WAIT2, CMP, HOLD, DONE.
- pick_ready is 1 only in PICK1 and PICK2. A handshake completes on (pick_valid && pick_ready).
- Pick is invalid if pick_addr ≥ NUM_CARDS, found[pick_addr] is set, or (in PICK2) pick_addr == first_card. An invalid pick is consumed with reject_pulse and causes no state change.
- PICK1 valid pick: first_card ← pick_addr, show_first ← 1, go to RD1.
- RD1: sym_rd = 1, sym_addr = first_card, go to WAIT1. WAIT1: sym1 ← sym_data, go to PICK2. RD2/WAIT2 mirror this for second_card/sym2, then go to CMP.
- CMP on equal symbols: set found for both cards, pairs_found+1, turns+1, match_pulse, clear both show flags. Go to DONE if pairs_found reaches NUM_CARDS/2, otherwise PICK1.
- CMP on unequal symbols: miss_pulse, turns+1, hold counter ← HIDE_CYCLES−1, go to HOLD.
- HOLD: count down. At 0, clear both show flags and go to PICK1.
- DONE: game_over = 1, pick_ready = 0. Only new_game or reset exits DONE.
- sym_rd = 0 and sym_addr = 0 outside RD1/RD2.
- turns holds at all-ones once reached; it does not wrap.
- new_game has priority over every state and event in its cycle. It clears found, pairs_found, turns, show flags and pulses, then goes to PICK1. first_card and second_card hold their values.

## Timing
- Reset (async assert, sync release): state PICK1, pick_ready 1, all other outputs 0.
- Reset mid-turn or mid-HOLD discards the turn with no event pulse.
- Second pick accepted at edge E: state sequence is RD2 (E), WAIT2 (E+1), CMP (E+2). match_pulse/miss_pulse and the found/pairs_found/turns updates are visible from edge E+3. Pulses last exactly 1 cycle.
- A miss holds the show flags for exactly HIDE_CYCLES cycles after miss_pulse rises.
- show flags rise the cycle after the accepting edge.
- All outputs are registered except pick_ready, sym_rd and sym_addr, which decode state.

## Configuration
- MATCH_HOLD_SKIP_EN defined: pick_ready = 1 in HOLD as well. A valid pick in HOLD ends the hold at once: show_second ← 0, and the pick is processed as a PICK1 pick in the same edge.
- Without it: picks in HOLD are not acknowledged, because pick_ready = 0.

## Test plan
- Symbols at cards 0 and 5 equal; pick 0 then 5 -> match_pulse 3 cycles after the second accept; found[0] = found[5] = 1; pairs_found = 1; turns = 1.
- Pick 1 then 2 with different symbols, HIDE_CYCLES = 10 -> miss_pulse; show flags stay 1 for 10 cycles, then 0; state returns to PICK1.
- Pick 0 twice, pick 40, pick an already-found card -> three reject_pulse events; no other state change.
- Play all 18 pairs -> game_over = 1, pick_ready = 0; new_game -> found = 0, turns = 0, game_over = 0.
- reset_n low during HOLD -> outputs zero immediately. With MATCH_HOLD_SKIP_EN, a pick at HOLD cycle 3 -> first_card = new pick, show_first = 1, show_second = 0.

Source files
------------

// File: rtl/match_turn_ctrl.sv
// Turn sequencer for the 6x6 memory-match game: accepts picks, reads symbols, scores pairs.
// Optional build macro MATCH_HOLD_SKIP_EN: a pick during the mismatch hold ends the hold early.
module match_turn_ctrl #(
  parameter int unsigned NUM_CARDS   = 36,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned SYM_W       = 5,
  parameter int unsigned HIDE_CYCLES = 25_000_000,
  parameter int unsigned TURN_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 new_game_i,
  input  logic                 pick_valid_i,
  input  logic [ADDR_W-1:0]    pick_addr_i,
  output logic                 pick_ready_o,
  output logic                 sym_rd_o,
  output logic [ADDR_W-1:0]    sym_addr_o,
  input  logic [SYM_W-1:0]     sym_data_i,
  output logic [ADDR_W-1:0]    first_card_o,
  output logic [ADDR_W-1:0]    second_card_o,
  output logic                 show_first_o,
  output logic                 show_second_o,
  output logic [NUM_CARDS-1:0] found_o,
  output logic                 match_pulse_o,
  output logic                 miss_pulse_o,
  output logic                 reject_pulse_o,
  output logic [ADDR_W-1:0]    pairs_found_o,
  output logic [TURN_W-1:0]    turns_o,
  output logic                 game_over_o
);

  localparam int unsigned HOLD_W     = $clog2(HIDE_CYCLES);
  localparam int unsigned CARD_SPACE = 1 << ADDR_W;
  localparam int unsigned CMP_W      = ADDR_W + 1;

  typedef enum logic [3:0] {
    S_PICK1, S_RD1, S_WAIT1, S_PICK2, S_RD2, S_WAIT2, S_CMP, S_HOLD, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     first_card_q, first_card_d, second_card_q, second_card_d;
  logic                  show_first_q, show_first_d, show_second_q, show_second_d;
  logic [NUM_CARDS-1:0]  found_q, found_d;
  logic                  match_q, match_d, miss_q, miss_d, reject_q, reject_d;
  logic [ADDR_W-1:0]     pairs_q, pairs_d;
  logic [TURN_W-1:0]     turns_q, turns_d;
  logic                  game_over_q, game_over_d;
  logic [SYM_W-1:0]      sym1_q, sym1_d, sym2_q, sym2_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;

  logic                  accept;
  logic                  pick_bad;
  logic [CARD_SPACE-1:0] found_ext;
  logic [ADDR_W-1:0]     pairs_inc;

  // Handshake and RAM port decode straight from the state
  always_comb begin
    pick_ready_o = (state_q == S_PICK1) || (state_q == S_PICK2);
`ifdef MATCH_HOLD_SKIP_EN
    if (state_q == S_HOLD) pick_ready_o = 1'b1;
`endif
    sym_rd_o   = (state_q == S_RD1) || (state_q == S_RD2);
    sym_addr_o = '0;
    if (state_q == S_RD1) sym_addr_o = first_card_q;
    if (state_q == S_RD2) sym_addr_o = second_card_q;
  end

  // Found vector widened to the full address space so any pick address indexes safely
  assign found_ext = CARD_SPACE'(found_q);
  assign accept    = pick_valid_i && pick_ready_o;
  assign pick_bad  = ({1'b0, pick_addr_i} >= CMP_W'(NUM_CARDS)) || found_ext[pick_addr_i] ||
                     ((state_q == S_PICK2) && (pick_addr_i == first_card_q));
  assign pairs_inc = pairs_q + ADDR_W'(1);

  always_comb begin
    state_d       = state_q;
    first_card_d  = first_card_q;
    second_card_d = second_card_q;
    show_first_d  = show_first_q;
    show_second_d = show_second_q;
    found_d       = found_q;
    match_d       = 1'b0;
    miss_d        = 1'b0;
    reject_d      = 1'b0;
    pairs_d       = pairs_q;
    turns_d       = turns_q;
    sym1_d        = sym1_q;
    sym2_d        = sym2_q;
    hold_d        = hold_q;

    if (new_game_i) begin
      state_d       = S_PICK1;
      show_first_d  = 1'b0;
      show_second_d = 1'b0;
      found_d       = '0;
      pairs_d       = '0;
      turns_d       = '0;
      hold_d        = '0;
    end else begin
      case (state_q)
        S_PICK1: begin
          if (accept) begin
            if (pick_bad) begin
              reject_d = 1'b1;
            end else begin
              first_card_d = pick_addr_i;
              show_first_d = 1'b1;
              state_d      = S_RD1;
            end
          end
        end
        S_RD1:   state_d = S_WAIT1;
        S_WAIT1: begin
          sym1_d  = sym_data_i;
          state_d = S_PICK2;
        end
        S_PICK2: begin
          if (accept) begin
            if (pick_bad) begin
              reject_d = 1'b1;
            end else begin
              second_card_d = pick_addr_i;
              show_second_d = 1'b1;
              state_d       = S_RD2;
            end
          end
        end
        S_RD2:   state_d = S_WAIT2;
        S_WAIT2: begin
          sym2_d  = sym_data_i;
          state_d = S_CMP;
        end
        S_CMP: begin
          if (turns_q != '1) turns_d = turns_q + TURN_W'(1);
          if (sym1_q == sym2_q) begin
            found_d       = found_q | (NUM_CARDS'(1) << first_card_q) | (NUM_CARDS'(1) << second_card_q);
            pairs_d       = pairs_inc;
            match_d       = 1'b1;
            show_first_d  = 1'b0;
            show_second_d = 1'b0;
            state_d       = (pairs_inc == ADDR_W'(NUM_CARDS / 2)) ? S_DONE : S_PICK1;
          end else begin
            miss_d  = 1'b1;
            hold_d  = HOLD_W'(HIDE_CYCLES - 1);
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_q == '0) begin
            show_first_d  = 1'b0;
            show_second_d = 1'b0;
            state_d       = S_PICK1;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
`ifdef MATCH_HOLD_SKIP_EN
          // Early pick abandons the hold and opens the next turn in the same edge
          if (accept) begin
            if (pick_bad) begin
              reject_d = 1'b1;
            end else begin
              show_second_d = 1'b0;
              first_card_d  = pick_addr_i;
              show_first_d  = 1'b1;
              hold_d        = '0;
              state_d       = S_RD1;
            end
          end
`endif
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_PICK1;
      endcase
    end

    game_over_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_PICK1;
      first_card_q  <= '0;
      second_card_q <= '0;
      show_first_q  <= 1'b0;
      show_second_q <= 1'b0;
      found_q       <= '0;
      match_q       <= 1'b0;
      miss_q        <= 1'b0;
      reject_q      <= 1'b0;
      pairs_q       <= '0;
      turns_q       <= '0;
      game_over_q   <= 1'b0;
      sym1_q        <= '0;
      sym2_q        <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      first_card_q  <= first_card_d;
      second_card_q <= second_card_d;
      show_first_q  <= show_first_d;
      show_second_q <= show_second_d;
      found_q       <= found_d;
      match_q       <= match_d;
      miss_q        <= miss_d;
      reject_q      <= reject_d;
      pairs_q       <= pairs_d;
      turns_q       <= turns_d;
      game_over_q   <= game_over_d;
      sym1_q        <= sym1_d;
      sym2_q        <= sym2_d;
      hold_q        <= hold_d;
    end
  end

  assign first_card_o   = first_card_q;
  assign second_card_o  = second_card_q;
  assign show_first_o   = show_first_q;
  assign show_second_o  = show_second_q;
  assign found_o        = found_q;
  assign match_pulse_o  = match_q;
  assign miss_pulse_o   = miss_q;
  assign reject_pulse_o = reject_q;
  assign pairs_found_o  = pairs_q;
  assign turns_o        = turns_q;
  assign game_over_o    = game_over_q;

endmodule

// File: tb/tb_match_turn_ctrl.sv
// Bench for match_turn_ctrl: directed scenarios plus a randomized full game against a score model.
module tb_match_turn_ctrl;
  localparam int unsigned NC = 36;
  localparam int unsigned AW = 6;
  localparam int unsigned SW = 5;
  localparam int unsigned HC = 10;
  localparam int unsigned TW = 8;

  logic clk = 1'b0;
  logic rst_n, new_game, pick_valid;
  logic [AW-1:0] pick_addr;
  logic pick_ready, sym_rd;
  logic [AW-1:0] sym_addr;
  logic [SW-1:0] sym_data;
  logic [AW-1:0] first_card, second_card;
  logic show_first, show_second;
  logic [NC-1:0] found;
  logic match_pulse, miss_pulse, reject_pulse;
  logic [AW-1:0] pairs_found;
  logic [TW-1:0] turns;
  logic game_over;

  logic [SW-1:0] sym_mem [64];
  logic [NC-1:0] m_found;
  int m_pairs, m_turns;
  int tests = 0;
  int fails = 0;

  match_turn_ctrl #(.NUM_CARDS(NC), .ADDR_W(AW), .SYM_W(SW), .HIDE_CYCLES(HC), .TURN_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .new_game_i(new_game), .pick_valid_i(pick_valid),
    .pick_addr_i(pick_addr), .pick_ready_o(pick_ready), .sym_rd_o(sym_rd),
    .sym_addr_o(sym_addr), .sym_data_i(sym_data), .first_card_o(first_card),
    .second_card_o(second_card), .show_first_o(show_first), .show_second_o(show_second),
    .found_o(found), .match_pulse_o(match_pulse), .miss_pulse_o(miss_pulse),
    .reject_pulse_o(reject_pulse), .pairs_found_o(pairs_found), .turns_o(turns),
    .game_over_o(game_over));

  always #5 clk = ~clk;

  // Symbol RAM: one-cycle registered read
  always @(posedge clk) if (sym_rd) sym_data <= sym_mem[sym_addr];

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pick(input int a);
    pick_valid = 1'b1;
    pick_addr  = AW'(a);
    cyc();
    pick_valid = 1'b0;
  endtask

  // Returns 3 cycles after the second accept, when the verdict is visible
  task automatic do_turn(input int a, input int b);
    pick(a); cyc(); cyc();
    pick(b); cyc(); cyc(); cyc();
  endtask

  task automatic model_turn(input int a, input int b, output bit hit);
    hit = (sym_mem[a] == sym_mem[b]);
    if (m_turns < 255) m_turns++;
    if (hit) begin
      m_found[a] = 1'b1;
      m_found[b] = 1'b1;
      m_pairs++;
    end
  endtask

  task automatic model_clear();
    m_found = '0; m_pairs = 0; m_turns = 0;
  endtask

  task automatic do_new_game();
    new_game = 1'b1; cyc(); new_game = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; new_game = 1'b0; pick_valid = 1'b0; pick_addr = '0;
    model_clear();
    #12;
    tests++; if (pick_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", pick_ready); end
    tests++; if ({show_first, show_second, match_pulse, miss_pulse, reject_pulse, game_over, sym_rd} !== 7'b0) begin
      fails++; $display("FAIL reset_flags got %b exp 0", {show_first, show_second, match_pulse, miss_pulse, reject_pulse, game_over, sym_rd}); end
    tests++; if ({found, turns, pairs_found, first_card, second_card} !== '0) begin
      fails++; $display("FAIL reset_regs got %h exp 0", {found, turns, pairs_found, first_card, second_card}); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_match();
    bit hit;
    pick(0); cyc(); cyc();
    tests++; if ({pick_ready, show_first, first_card} !== {1'b1, 1'b1, 6'd0}) begin
      fails++; $display("FAIL match_first got %b exp 1_1_000000", {pick_ready, show_first, first_card}); end
    pick(5);
    tests++; if ({show_second, second_card} !== {1'b1, 6'd5}) begin
      fails++; $display("FAIL match_second got %b exp 1_000101", {show_second, second_card}); end
    cyc(); cyc();
    tests++; if (match_pulse !== 1'b0) begin fails++; $display("FAIL match_early got %b exp 0", match_pulse); end
    cyc();
    model_turn(0, 5, hit);
    tests++; if ({match_pulse, miss_pulse} !== {hit, !hit}) begin
      fails++; $display("FAIL match_pulse got %b exp %b", {match_pulse, miss_pulse}, {hit, !hit}); end
    tests++; if (found !== m_found) begin fails++; $display("FAIL match_found got %h exp %h", found, m_found); end
    tests++; if ({pairs_found, turns} !== {AW'(m_pairs), TW'(m_turns)}) begin
      fails++; $display("FAIL match_counts got %0d/%0d exp %0d/%0d", pairs_found, turns, m_pairs, m_turns); end
    tests++; if ({show_first, show_second, pick_ready} !== 3'b001) begin
      fails++; $display("FAIL match_hide got %b exp 001", {show_first, show_second, pick_ready}); end
    cyc();
    tests++; if (match_pulse !== 1'b0) begin fails++; $display("FAIL match_width got %b exp 0", match_pulse); end
  endtask

  task automatic test_miss();
    bit hit;
    int shown, extra;
    do_turn(1, 2);
    model_turn(1, 2, hit);
    tests++; if ({match_pulse, miss_pulse} !== {hit, !hit}) begin
      fails++; $display("FAIL miss_pulse got %b exp %b", {match_pulse, miss_pulse}, {hit, !hit}); end
    tests++; if (turns !== TW'(m_turns)) begin fails++; $display("FAIL miss_turns got %0d exp %0d", turns, m_turns); end
    shown = (show_first && show_second) ? 1 : 0;
    extra = 0;
    for (int k = 0; k < int'(HC) + 3; k++) begin
      cyc();
      if (miss_pulse) extra++;
      if (show_first && show_second) shown++;
    end
    tests++; if (shown != int'(HC)) begin fails++; $display("FAIL miss_hold got %0d exp %0d", shown, HC); end
    tests++; if (extra != 0) begin fails++; $display("FAIL miss_width got %0d exp 0", extra); end
    tests++; if ({show_first, show_second, pick_ready} !== 3'b001) begin
      fails++; $display("FAIL miss_return got %b exp 001", {show_first, show_second, pick_ready}); end
  endtask

  task automatic test_reject();
    bit hit;
    pick(0);
    tests++; if ({reject_pulse, pick_ready, show_first} !== 3'b110) begin
      fails++; $display("FAIL rej_found got %b exp 110", {reject_pulse, pick_ready, show_first}); end
    pick(40);
    tests++; if ({reject_pulse, pick_ready, show_first} !== 3'b110) begin
      fails++; $display("FAIL rej_range got %b exp 110", {reject_pulse, pick_ready, show_first}); end
    pick(3);
    tests++; if ({reject_pulse, show_first, first_card} !== {2'b01, 6'd3}) begin
      fails++; $display("FAIL rej_valid got %b exp 01_000011", {reject_pulse, show_first, first_card}); end
    cyc(); cyc();
    pick(3);
    tests++; if ({reject_pulse, pick_ready, show_second, first_card} !== {3'b110, 6'd3}) begin
      fails++; $display("FAIL rej_same got %b exp 110_000011", {reject_pulse, pick_ready, show_second, first_card}); end
    pick(5);
    tests++; if ({reject_pulse, pick_ready, show_second} !== 3'b110) begin
      fails++; $display("FAIL rej_found2 got %b exp 110", {reject_pulse, pick_ready, show_second}); end
    tests++; if (turns !== TW'(m_turns)) begin fails++; $display("FAIL rej_turns got %0d exp %0d", turns, m_turns); end
    pick(4); cyc(); cyc(); cyc();
    model_turn(3, 4, hit);
    tests++; if (miss_pulse !== !hit) begin fails++; $display("FAIL rej_finish got %b exp %b", miss_pulse, !hit); end
    repeat (HC) cyc();
  endtask

  task automatic test_hold_pick();
    bit hit;
    do_turn(6, 7);
    model_turn(6, 7, hit);
    cyc(); cyc(); cyc();
`ifdef MATCH_HOLD_SKIP_EN
    tests++; if (pick_ready !== 1'b1) begin fails++; $display("FAIL skip_ready got %b exp 1", pick_ready); end
    pick(8);
    tests++; if ({first_card, show_first, show_second, second_card} !== {6'd8, 2'b10, 6'd7}) begin
      fails++; $display("FAIL skip_pick got %b exp 001000_10_000111", {first_card, show_first, show_second, second_card}); end
    cyc(); cyc();
    pick(9); cyc(); cyc(); cyc();
    model_turn(8, 9, hit);
    tests++; if (miss_pulse !== !hit) begin fails++; $display("FAIL skip_turn got %b exp %b", miss_pulse, !hit); end
    tests++; if (turns !== TW'(m_turns)) begin fails++; $display("FAIL skip_turns got %0d exp %0d", turns, m_turns); end
    repeat (HC) cyc();
`else
    tests++; if (pick_ready !== 1'b0) begin fails++; $display("FAIL hold_ready got %b exp 0", pick_ready); end
    pick(8);
    tests++; if ({first_card, show_first, reject_pulse} !== {6'd6, 2'b10}) begin
      fails++; $display("FAIL hold_ignore got %b exp 000110_10", {first_card, show_first, reject_pulse}); end
    repeat (HC) cyc();
    tests++; if ({show_first, show_second, pick_ready} !== 3'b001) begin
      fails++; $display("FAIL hold_end got %b exp 001", {show_first, show_second, pick_ready}); end
`endif
  endtask

  task automatic test_reset_hold();
    bit hit;
    do_turn(10, 11);
    model_turn(10, 11, hit);
    cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({show_first, show_second, miss_pulse, pick_ready} !== 4'b0001) begin
      fails++; $display("FAIL rsthold_flags got %b exp 0001", {show_first, show_second, miss_pulse, pick_ready}); end
    tests++; if ({found, turns, pairs_found, first_card, second_card} !== '0) begin
      fails++; $display("FAIL rsthold_regs got %h exp 0", {found, turns, pairs_found, first_card, second_card}); end
    #1 rst_n = 1'b1;
    model_clear();
    cyc();
    tests++; if ({pick_ready, miss_pulse, match_pulse} !== 3'b100) begin
      fails++; $display("FAIL rsthold_after got %b exp 100", {pick_ready, miss_pulse, match_pulse}); end
  endtask

  task automatic test_turn_saturation();
    bit hit;
    for (int t = 0; t < 258; t++) begin
      do_turn(1, 2);
      model_turn(1, 2, hit);
      if (t >= 250) begin
        tests++; if (turns !== TW'(m_turns)) begin fails++; $display("FAIL sat_turns t=%0d got %0d exp %0d", t, turns, m_turns); end
      end
      repeat (HC) cyc();
    end
  endtask

  task automatic test_random_game();
    int perm [NC];
    int q [$];
    int a, b, tmp, guard, last_a;
    bit hit;
    for (int i = 0; i < int'(NC); i++) perm[i] = i / 2;
    for (int i = int'(NC) - 1; i > 0; i--) begin
      tmp = int'($urandom_range(0, i));
      a = perm[i]; perm[i] = perm[tmp]; perm[tmp] = a;
    end
    for (int i = 0; i < int'(NC); i++) sym_mem[i] = SW'(perm[i]);
    last_a = int'(first_card);
    do_new_game();
    tests++; if ({found, turns, pairs_found, game_over, pick_ready} !== {{NC{1'b0}}, 8'd0, 6'd0, 2'b01}) begin
      fails++; $display("FAIL ng_clear got %h/%0d/%0d/%b exp 0/0/0/01", found, turns, pairs_found, {game_over, pick_ready}); end
    tests++; if (first_card !== AW'(last_a)) begin fails++; $display("FAIL ng_first got %0d exp %0d", first_card, last_a); end
    guard = 0;
    while (m_pairs < int'(NC / 2) && guard < 400) begin
      guard++;
      q.delete();
      for (int i = 0; i < int'(NC); i++) if (!m_found[i]) q.push_back(i);
      a = q[$urandom_range(0, q.size() - 1)];
      b = a;
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < int'(NC); j++) if (j != a && !m_found[j] && sym_mem[j] == sym_mem[a]) b = j;
      end
      while (b == a) b = q[$urandom_range(0, q.size() - 1)];
      last_a = a;
      do_turn(a, b);
      model_turn(a, b, hit);
      tests++; if ({match_pulse, miss_pulse} !== {hit, !hit}) begin
        fails++; $display("FAIL game_pulse %0d/%0d got %b exp %b", a, b, {match_pulse, miss_pulse}, {hit, !hit}); end
      tests++; if ({found, pairs_found, turns} !== {m_found, AW'(m_pairs), TW'(m_turns)}) begin
        fails++; $display("FAIL game_score got %h/%0d/%0d exp %h/%0d/%0d", found, pairs_found, turns, m_found, m_pairs, m_turns); end
      tests++; if (game_over !== (m_pairs == int'(NC / 2))) begin
        fails++; $display("FAIL game_over_flag got %b exp %b", game_over, m_pairs == int'(NC / 2)); end
      if (!hit) repeat (HC) cyc();
    end
    tests++; if ({game_over, pick_ready} !== 2'b10) begin fails++; $display("FAIL done_state got %b exp 10", {game_over, pick_ready}); end
    pick(0);
    tests++; if ({game_over, reject_pulse, pick_ready} !== 3'b100) begin
      fails++; $display("FAIL done_pick got %b exp 100", {game_over, reject_pulse, pick_ready}); end
    do_new_game();
    tests++; if ({found, turns, pairs_found, game_over, pick_ready} !== {{NC{1'b0}}, 8'd0, 6'd0, 2'b01}) begin
      fails++; $display("FAIL done_newgame got %h/%0d/%0d/%b exp 0/0/0/01", found, turns, pairs_found, {game_over, pick_ready}); end
    tests++; if (first_card !== AW'(last_a)) begin fails++; $display("FAIL done_first got %0d exp %0d", first_card, last_a); end
  endtask

  initial begin
    // Directed board: card i pairs with card i+18, except cards 0 and 5 are a pair
    for (int i = 0; i < 64; i++) sym_mem[i] = (i < int'(NC)) ? SW'(i % 18) : '1;
    sym_mem[5]  = SW'(0);
    sym_mem[18] = SW'(5);
    test_reset();
    test_match();
    test_miss();
    test_reject();
    test_hold_pick();
    test_reset_hold();
    test_turn_saturation();
    test_random_game();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
